// File: rtl/ram_ptr.sv
// ram_ptr: RAM address pointer with post-increment/post-decrement on every
// RAM access, loadable over the nibble-coded source/destination bus, plus a
// small mode/status register (mode, wrap enable, sticky boundary flag).
// There is no FSM here; the full internal state (ptr, mode, wrap, bound) is
// observable through ram_addr and a MODE read.
module ram_ptr #(
   parameter int          DATA_WIDTH     = 8,
   parameter int          RAM_ADDR_WIDTH = 8,
   parameter logic [3:0]  RAM_SEL        = 4'h3,
   parameter logic [3:0]  PTR_SEL        = 4'h4,
   parameter logic [3:0]  MODE_SEL       = 4'h5
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [DATA_WIDTH-1:0]     addr_bus,
   input  logic [DATA_WIDTH-1:0]     data_bus_in,
   output logic [DATA_WIDTH-1:0]     data_bus_out,
   output logic [RAM_ADDR_WIDTH-1:0] ram_addr
);

   localparam logic [RAM_ADDR_WIDTH-1:0] ONE = RAM_ADDR_WIDTH'(1);

   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_INC  = 2'b01;
   localparam logic [1:0] MODE_DEC  = 2'b10;

   logic [RAM_ADDR_WIDTH-1:0] ptr;
   logic [RAM_ADDR_WIDTH-1:0] ptr_next;
   logic [1:0]                mode;
   logic                      wrap;
   logic                      bound;

   logic [3:0] src_code;
   logic [3:0] dst_code;
   logic       ren_ram, wen_ram, ren_ptr, wen_ptr, ren_mode, wen_mode;
   logic       access;
   logic       step_up, step_dn;
   logic       at_max, at_min;
   logic       blocked;
   logic       hit;

   assign src_code = addr_bus[7:4];
   assign dst_code = addr_bus[3:0];

   assign ren_ram  = (src_code == RAM_SEL);
   assign wen_ram  = (dst_code == RAM_SEL);
   assign ren_ptr  = (src_code == PTR_SEL);
   assign wen_ptr  = (dst_code == PTR_SEL);
   assign ren_mode = (src_code == MODE_SEL);
   assign wen_mode = (dst_code == MODE_SEL);

   // A RAM->RAM copy raises both enables but is still one access, so one step.
   assign access  = ren_ram | wen_ram;

   // Steps always use the mode/wrap held during this cycle, even if MODE is
   // being rewritten at the same edge. Reserved mode 11 falls through as hold.
   assign step_up = access && (mode == MODE_INC);
   assign step_dn = access && (mode == MODE_DEC);
   assign at_max  = &ptr;
   assign at_min  = ~|ptr;

   // With wrap disabled, a step that would cross either end is suppressed.
   assign blocked = !wrap && ((step_up && at_max) || (step_dn && at_min));

   // A pointer load discards the step entirely, including its boundary report.
   assign hit     = blocked && !wen_ptr;

   // Next pointer value: load beats step, step beats hold.
   always_comb begin
      ptr_next = ptr;
      if (wen_ptr) begin
         ptr_next = data_bus_in[RAM_ADDR_WIDTH-1:0];
      end else if (step_up && !blocked) begin
         ptr_next = ptr + ONE;
      end else if (step_dn && !blocked) begin
         ptr_next = ptr - ONE;
      end
   end

   // Pointer register; ram_addr is taken straight from it so it is glitch-free.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else begin
         ptr <= ptr_next;
      end
   end

   // Mode/status register; a boundary hit in the same cycle as a MODE write
   // wins over the write's clear of the sticky flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode  <= MODE_HOLD;
         wrap  <= 1'b1;
         bound <= 1'b0;
      end else begin
         if (wen_mode) begin
            mode  <= data_bus_in[1:0];
            wrap  <= data_bus_in[2];
            bound <= hit;
         end else begin
            bound <= bound | hit;
         end
      end
   end

   // Combinational read mux; reads see the pre-update register values.
   always_comb begin
      data_bus_out = '0;
      if (ren_ptr) begin
         data_bus_out[RAM_ADDR_WIDTH-1:0] = ptr;
      end else if (ren_mode) begin
         data_bus_out[3:0] = {bound, wrap, mode};
      end
   end

   assign ram_addr = ptr;

endmodule

// File: tb/tb_ram_ptr.sv
// tb_ram_ptr: directed scenarios plus randomized bus traffic for ram_ptr,
// checked every cycle against a behavioural model of the pointer/mode rules.
module tb_ram_ptr;

   localparam int W = 8;
   localparam int A = 8;

   // ---------------- clock / reset ----------------
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] addr_bus = '0;
   logic [W-1:0] data_bus_in = '0;
   logic [W-1:0] data_bus_out;
   logic [A-1:0] ram_addr;

   always #5 clk = ~clk;

   ram_ptr dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .addr_bus     (addr_bus),
      .data_bus_in  (data_bus_in),
      .data_bus_out (data_bus_out),
      .ram_addr     (ram_addr)
   );

   // ---------------- scoreboard counters ----------------
   int n_vec  = 0;
   int n_miss = 0;
   logic cmp_en = 1'b0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic [A-1:0] ptr;
      logic [1:0]   mode;
      logic         wrap;
      logic         bound;
   } model_t;

   model_t m;

   // Next model state from the architectural rules, using integer arithmetic.
   function automatic model_t model_next(input model_t s, input logic [W-1:0] a,
                                         input logic [W-1:0] d);
      model_t n;
      int     src, dst, target, span;
      bit     acc, hit;
      n      = s;
      hit    = 0;
      src    = int'(a[7:4]);
      dst    = int'(a[3:0]);
      acc    = (src == 3) || (dst == 3);
      span   = 1 << A;
      if (dst == 4) begin
         n.ptr = d[A-1:0];
      end else if (acc && (s.mode == 2'd1 || s.mode == 2'd2)) begin
         target = int'(s.ptr) + ((s.mode == 2'd1) ? 1 : -1);
         if (target < 0 || target >= span) begin
            if (s.wrap) n.ptr = A'((target + span) % span);
            else        hit   = 1;
         end else begin
            n.ptr = A'(target);
         end
      end
      if (dst == 5) begin
         n.mode  = d[1:0];
         n.wrap  = d[2];
         n.bound = hit;
      end else begin
         n.bound = s.bound | hit;
      end
      return n;
   endfunction

   function automatic logic [W-1:0] model_read(input model_t s, input logic [W-1:0] a);
      logic [W-1:0] r;
      r = '0;
      if (a[7:4] == 4'd4)      r = W'(s.ptr);
      else if (a[7:4] == 4'd5) r = W'({s.bound, s.wrap, s.mode});
      return r;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= '{ptr: '0, mode: 2'b00, wrap: 1'b1, bound: 1'b0};
      else        m <= model_next(m, addr_bus, data_bus_in);
   end

   // Per-cycle compare, well clear of the rising edge.
   always @(negedge clk) begin
      #2;
      if (cmp_en) begin
         check("ram_addr", W'(ram_addr), W'(m.ptr));
         check("data_bus_out", data_bus_out, model_read(m, addr_bus));
      end
   end

   // ---------------- driver ----------------
   task automatic drive(input logic [W-1:0] a, input logic [W-1:0] d);
      @(negedge clk);
      addr_bus    = a;
      data_bus_in = d;
   endtask

   // ---------------- directed + random stimulus ----------------
   initial begin
      logic [W-1:0] ra, rd;
      #12 rst_n = 1'b1;
      cmp_en = 1'b1;

      // reset state
      drive(8'h50, 8'h00); #2;
      check("rst_addr", W'(ram_addr), 8'h00);
      check("rst_mode", data_bus_out, 8'h04);

      // load and walk
      drive(8'h04, 8'h10);
      drive(8'h05, 8'h05);
      for (int i = 0; i < 4; i++) begin
         drive(8'h03, W'($urandom));
         #2 check("walk", W'(ram_addr), 8'h10 + W'(i));
      end
      drive(8'h00, 8'h00); #2 check("walk_after", W'(ram_addr), 8'h14);

      // wrap up and down
      drive(8'h04, 8'hFF);
      drive(8'h05, 8'h05);
      drive(8'h30, 8'h00);
      drive(8'h50, 8'h00); #2;
      check("wrap_up_addr", W'(ram_addr), 8'h00);
      check("wrap_up_mode", data_bus_out, 8'h05);
      drive(8'h04, 8'h00);
      drive(8'h05, 8'h06);
      drive(8'h03, 8'h00);
      drive(8'h00, 8'h00); #2 check("wrap_dn_addr", W'(ram_addr), 8'hFF);

      // saturate
      drive(8'h04, 8'hFF);
      drive(8'h05, 8'h01);
      drive(8'h03, 8'h00);
      drive(8'h03, 8'h00);
      drive(8'h50, 8'h00); #2;
      check("sat_addr", W'(ram_addr), 8'hFF);
      check("sat_mode", data_bus_out, 8'h09);
      drive(8'h05, 8'h01);
      drive(8'h50, 8'h00); #2 check("sat_clear", data_bus_out, 8'h01);

      // collisions
      drive(8'h05, 8'h05);
      drive(8'h34, 8'h40);
      drive(8'h00, 8'h00); #2 check("col_ptr_wr", W'(ram_addr), 8'h40);
      drive(8'h04, 8'h20);
      drive(8'h33, 8'h00);
      drive(8'h00, 8'h00); #2 check("col_copy", W'(ram_addr), 8'h21);
      drive(8'h35, 8'h00);
      drive(8'h03, 8'h00);
      drive(8'h50, 8'h00); #2;
      check("col_mode_wr", W'(ram_addr), 8'h22);
      check("col_mode_rd", data_bus_out, 8'h00);

      // read mux
      drive(8'h04, 8'h33);
      drive(8'h40, 8'h00); #2 check("mux_ptr", data_bus_out, 8'h33);
      drive(8'h30, 8'h00); #2 check("mux_ram", data_bus_out, 8'h00);
      drive(8'h70, 8'h00); #2 check("mux_unused", data_bus_out, 8'h00);

      // asynchronous reset mid-run
      drive(8'h04, 8'h5A);
      drive(8'h00, 8'h00); #2 check("pre_rst", W'(ram_addr), 8'h5A);
      #1 rst_n = 1'b0;
      #1 check("async_rst", W'(ram_addr), 8'h00);
      drive(8'h50, 8'h00); #2 check("rst_mode2", data_bus_out, 8'h04);
      #1 rst_n = 1'b1;

      // randomized traffic
      for (int i = 0; i < 2000; i++) begin
         ra = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
         rd = W'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 3))
               0: rd = 8'h00;
               1: rd = 8'hFF;
               2: rd = 8'h01;
               default: rd = 8'hFE;
            endcase
         end
         drive(ra, rd);
      end
      drive(8'h00, 8'h00);
      @(negedge clk); #3;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
